// File: rtl/axi_read_port_arbiter.sv
// Shares one AXI4 read channel (AR/R) among NUM_PORTS masters; requester index rides in the low ARID bits.
// Optional build macro AXI_ARB_FIXED_PRIORITY_EN selects lowest-index-wins arbitration instead of round-robin.
module axi_read_port_arbiter #(
  parameter int NUM_PORTS       = 2,
  parameter int IDX_WIDTH       = 1,
  parameter int ID_WIDTH        = 8,
  parameter int ADDR_WIDTH      = 24,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                             aclk,
  input  logic                             rst,
  input  logic [NUM_PORTS*ID_WIDTH-1:0]    s_axi_arid,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  s_axi_araddr,
  input  logic [NUM_PORTS*8-1:0]           s_axi_arlen,
  input  logic [NUM_PORTS*3-1:0]           s_axi_arsize,
  input  logic [NUM_PORTS*2-1:0]           s_axi_arburst,
  input  logic [NUM_PORTS-1:0]             s_axi_arvalid,
  output logic [NUM_PORTS-1:0]             s_axi_arready,
  output logic [NUM_PORTS*ID_WIDTH-1:0]    s_axi_rid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axi_rdata,
  output logic [NUM_PORTS*2-1:0]           s_axi_rresp,
  output logic [NUM_PORTS-1:0]             s_axi_rlast,
  output logic [NUM_PORTS-1:0]             s_axi_rvalid,
  input  logic [NUM_PORTS-1:0]             s_axi_rready,
  output logic [ID_WIDTH-1:0]              m_axi_arid,
  output logic [ADDR_WIDTH-1:0]            m_axi_araddr,
  output logic [7:0]                       m_axi_arlen,
  output logic [2:0]                       m_axi_arsize,
  output logic [1:0]                       m_axi_arburst,
  output logic                             m_axi_arlock,
  output logic [3:0]                       m_axi_arcache,
  output logic [2:0]                       m_axi_arprot,
  output logic                             m_axi_arvalid,
  input  logic                             m_axi_arready,
  input  logic [ID_WIDTH-1:0]              m_axi_rid,
  input  logic [DATA_WIDTH-1:0]            m_axi_rdata,
  input  logic [1:0]                       m_axi_rresp,
  input  logic                             m_axi_rlast,
  input  logic                             m_axi_rvalid,
  output logic                             m_axi_rready
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;
  localparam int         CNT_W   = 4;

  logic [0:0]           r_state;
  logic [IDX_WIDTH-1:0] r_ptr;
  logic [IDX_WIDTH-1:0] r_winner;
  logic [CNT_W-1:0]     r_cnt [NUM_PORTS];

  logic [ID_WIDTH-1:0]   w_arid    [NUM_PORTS];
  logic [ADDR_WIDTH-1:0] w_araddr  [NUM_PORTS];
  logic [7:0]            w_arlen   [NUM_PORTS];
  logic [2:0]            w_arsize  [NUM_PORTS];
  logic [1:0]            w_arburst [NUM_PORTS];
  logic [NUM_PORTS-1:0]  w_elig;
  logic [NUM_PORTS-1:0]  w_inc;
  logic [NUM_PORTS-1:0]  w_dec;
  logic                  w_found;
  logic [IDX_WIDTH-1:0]  w_winner;
  logic [IDX_WIDTH-1:0]  w_scan_idx;
  logic [IDX_WIDTH-1:0]  w_ridx;
  logic                  w_ridx_ok;
  logic [NUM_PORTS*IDX_WIDTH-1:0] w_unused_arid_hi;

  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b010;

  assign w_ridx       = m_axi_rid[IDX_WIDTH-1:0];
  assign w_ridx_ok    = int'(w_ridx) < NUM_PORTS;
  // Beats tagged for a nonexistent port are drained so the memory side never stalls on them.
  assign m_axi_rready = w_ridx_ok ? s_axi_rready[w_ridx] : 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign w_arid[gi]    = s_axi_arid[gi*ID_WIDTH +: ID_WIDTH];
      assign w_araddr[gi]  = s_axi_araddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_arlen[gi]   = s_axi_arlen[gi*8 +: 8];
      assign w_arsize[gi]  = s_axi_arsize[gi*3 +: 3];
      assign w_arburst[gi] = s_axi_arburst[gi*2 +: 2];
      assign w_unused_arid_hi[gi*IDX_WIDTH +: IDX_WIDTH] =
        s_axi_arid[gi*ID_WIDTH + ID_WIDTH - IDX_WIDTH +: IDX_WIDTH];

      assign w_elig[gi] = s_axi_arvalid[gi] && (r_cnt[gi] < CNT_W'(MAX_OUTSTANDING));
      assign s_axi_arready[gi] = !rst && (r_state == S_IDLE) && w_found &&
                                 (w_winner == IDX_WIDTH'(gi));
      assign w_inc[gi] = (r_state == S_ISSUE) && m_axi_arready && (r_winner == IDX_WIDTH'(gi));
      assign w_dec[gi] = m_axi_rvalid && m_axi_rready && m_axi_rlast && (w_ridx == IDX_WIDTH'(gi));

      assign s_axi_rid[gi*ID_WIDTH +: ID_WIDTH] =
        {{IDX_WIDTH{1'b0}}, m_axi_rid[ID_WIDTH-1:IDX_WIDTH]};
      assign s_axi_rdata[gi*DATA_WIDTH +: DATA_WIDTH] = m_axi_rdata;
      assign s_axi_rresp[gi*2 +: 2] = m_axi_rresp;
      assign s_axi_rlast[gi]  = m_axi_rlast;
      assign s_axi_rvalid[gi] = m_axi_rvalid && (w_ridx == IDX_WIDTH'(gi));

      // Simultaneous issue and completion cancel; stale completions after reset saturate at zero.
      always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
          r_cnt[gi] <= '0;
        end else if (w_inc[gi] && !w_dec[gi]) begin
          r_cnt[gi] <= r_cnt[gi] + 1'b1;
        end else if (!w_inc[gi] && w_dec[gi] && (r_cnt[gi] != '0)) begin
          r_cnt[gi] <= r_cnt[gi] - 1'b1;
        end
      end
    end
  endgenerate

`ifdef AXI_ARB_FIXED_PRIORITY_EN
  always_comb begin
    w_found    = 1'b0;
    w_winner   = '0;
    w_scan_idx = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      w_scan_idx = IDX_WIDTH'(k);
      if (w_elig[w_scan_idx]) begin
        w_found  = 1'b1;
        w_winner = w_scan_idx;
      end
    end
  end
`else
  // Scan starts one past the last winner so each eligible port is served within NUM_PORTS grants.
  always_comb begin
    w_found    = 1'b0;
    w_winner   = '0;
    w_scan_idx = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      w_scan_idx = IDX_WIDTH'((int'(r_ptr) + k) % NUM_PORTS);
      if (!w_found && w_elig[w_scan_idx]) begin
        w_found  = 1'b1;
        w_winner = w_scan_idx;
      end
    end
  end
`endif

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_winner      <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_arid    <= '0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_arsize  <= '0;
      m_axi_arburst <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_winner      <= w_winner;
            m_axi_arid    <= {w_arid[w_winner][ID_WIDTH-IDX_WIDTH-1:0], w_winner};
            m_axi_araddr  <= w_araddr[w_winner];
            m_axi_arlen   <= w_arlen[w_winner];
            m_axi_arsize  <= w_arsize[w_winner];
            m_axi_arburst <= w_arburst[w_winner];
            m_axi_arvalid <= 1'b1;
            r_state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            r_ptr         <= r_winner;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_port_arbiter.sv
// Directed bench for axi_read_port_arbiter: AR and R scoreboards filled at stimulus, drained by negedge monitors.
module tb_axi_read_port_arbiter;
  localparam int NP = 2;
  localparam int IW = 1;
  localparam int ID = 8;
  localparam int AW = 24;
  localparam int DW = 64;

  logic aclk = 1'b0;
  logic rst  = 1'b1;
  always #5 aclk = ~aclk;

  logic [NP*ID-1:0] s_axi_arid;
  logic [NP*AW-1:0] s_axi_araddr;
  logic [NP*8-1:0]  s_axi_arlen;
  logic [NP*3-1:0]  s_axi_arsize;
  logic [NP*2-1:0]  s_axi_arburst;
  logic [NP-1:0]    s_axi_arvalid, s_axi_arready;
  logic [NP*ID-1:0] s_axi_rid;
  logic [NP*DW-1:0] s_axi_rdata;
  logic [NP*2-1:0]  s_axi_rresp;
  logic [NP-1:0]    s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [ID-1:0]    m_axi_arid;
  logic [AW-1:0]    m_axi_araddr;
  logic [7:0]       m_axi_arlen;
  logic [2:0]       m_axi_arsize;
  logic [1:0]       m_axi_arburst;
  logic             m_axi_arlock;
  logic [3:0]       m_axi_arcache;
  logic [2:0]       m_axi_arprot;
  logic             m_axi_arvalid, m_axi_arready;
  logic [ID-1:0]    m_axi_rid;
  logic [DW-1:0]    m_axi_rdata;
  logic [1:0]       m_axi_rresp;
  logic             m_axi_rlast, m_axi_rvalid, m_axi_rready;

  axi_read_port_arbiter #(.NUM_PORTS(NP), .IDX_WIDTH(IW), .ID_WIDTH(ID), .ADDR_WIDTH(AW),
                          .DATA_WIDTH(DW), .MAX_OUTSTANDING(4)) u_dut (
    .aclk(aclk), .rst(rst),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  // Three-port instance, used only for the out-of-range RID sink path.
  logic [3*ID-1:0] s3_arid;
  logic [3*AW-1:0] s3_araddr;
  logic [3*8-1:0]  s3_arlen;
  logic [3*3-1:0]  s3_arsize;
  logic [3*2-1:0]  s3_arburst;
  logic [2:0]      s3_arvalid, s3_arready, s3_rlast, s3_rvalid, s3_rready;
  logic [3*ID-1:0] s3_rid;
  logic [3*DW-1:0] s3_rdata;
  logic [3*2-1:0]  s3_rresp;
  logic [ID-1:0]   m3_arid, m3_rid;
  logic [AW-1:0]   m3_araddr;
  logic [7:0]      m3_arlen;
  logic [2:0]      m3_arsize, m3_arprot;
  logic [1:0]      m3_arburst, m3_rresp;
  logic            m3_arlock, m3_arvalid, m3_arready, m3_rlast, m3_rvalid, m3_rready;
  logic [3:0]      m3_arcache;
  logic [DW-1:0]   m3_rdata;

  axi_read_port_arbiter #(.NUM_PORTS(3), .IDX_WIDTH(2), .ID_WIDTH(ID), .ADDR_WIDTH(AW),
                          .DATA_WIDTH(DW), .MAX_OUTSTANDING(4)) u_dut3 (
    .aclk(aclk), .rst(rst),
    .s_axi_arid(s3_arid), .s_axi_araddr(s3_araddr), .s_axi_arlen(s3_arlen),
    .s_axi_arsize(s3_arsize), .s_axi_arburst(s3_arburst), .s_axi_arvalid(s3_arvalid),
    .s_axi_arready(s3_arready), .s_axi_rid(s3_rid), .s_axi_rdata(s3_rdata),
    .s_axi_rresp(s3_rresp), .s_axi_rlast(s3_rlast), .s_axi_rvalid(s3_rvalid),
    .s_axi_rready(s3_rready),
    .m_axi_arid(m3_arid), .m_axi_araddr(m3_araddr), .m_axi_arlen(m3_arlen),
    .m_axi_arsize(m3_arsize), .m_axi_arburst(m3_arburst), .m_axi_arlock(m3_arlock),
    .m_axi_arcache(m3_arcache), .m_axi_arprot(m3_arprot), .m_axi_arvalid(m3_arvalid),
    .m_axi_arready(m3_arready), .m_axi_rid(m3_rid), .m_axi_rdata(m3_rdata),
    .m_axi_rresp(m3_rresp), .m_axi_rlast(m3_rlast), .m_axi_rvalid(m3_rvalid),
    .m_axi_rready(m3_rready)
  );

  int n_cmp = 0;
  int n_mis = 0;
  logic [39:0] ar_q[$];  // {m_arid, m_araddr, m_arlen}
  logic [79:0] r_q[$];   // {port, s_rid, s_rdata}

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  task automatic set_port(input int p, input logic [7:0] id, input logic [23:0] addr,
                          input logic [7:0] len);
    s_axi_arid[p*ID +: ID]   = id;
    s_axi_araddr[p*AW +: AW] = addr;
    s_axi_arlen[p*8 +: 8]    = len;
    s_axi_arsize[p*3 +: 3]   = 3'd3;
    s_axi_arburst[p*2 +: 2]  = 2'd1;
  endtask

  task automatic push_ar(input int p, input logic [7:0] id, input logic [23:0] addr,
                         input logic [7:0] len);
    logic [IW-1:0] pi;
    pi = IW'(p);
    ar_q.push_back({id[ID-IW-1:0], pi, addr, len});
  endtask

  task automatic drive_r(input int p, input logic [7:0] id, input logic [63:0] data,
                         input logic last);
    logic [IW-1:0] pi;
    pi = IW'(p);
    m_axi_rid    = {id[ID-IW-1:0], pi};
    m_axi_rdata  = data;
    m_axi_rlast  = last;
    m_axi_rvalid = 1'b1;
  endtask

  task automatic wait_ar_empty(input string tag);
    for (int i = 0; i < 30 && ar_q.size() != 0; i++) tick();
    check(tag, 128'(ar_q.size()), 128'd0);
  endtask

  always @(negedge aclk) begin
    logic [39:0] ea;
    logic [79:0] er;
    if (!rst && m_axi_arvalid && m_axi_arready) begin
      if (ar_q.size() == 0) begin
        check("ar_unexpected", 128'd0, 128'd1);
      end else begin
        ea = ar_q.pop_front();
        check("ar_issue", 128'({m_axi_arid, m_axi_araddr, m_axi_arlen}), 128'(ea));
        $display("AR  id=%0h addr=%0h len=%0d", m_axi_arid, m_axi_araddr, m_axi_arlen);
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (s_axi_rvalid[p] && s_axi_rready[p]) begin
        if (r_q.size() == 0) begin
          check("r_unexpected", 128'd0, 128'd1);
        end else begin
          er = r_q.pop_front();
          check("r_beat", 128'({8'(p), s_axi_rid[p*ID +: ID], s_axi_rdata[p*DW +: DW]}), 128'(er));
          $display("R   port=%0d rid=%0h data=%0h", p, s_axi_rid[p*ID +: ID], s_axi_rdata[p*DW +: DW]);
        end
      end
    end
  end

`ifdef AXI_ARB_FIXED_PRIORITY_EN
  localparam logic [3:0] T2_PORTS = 4'b0000;
`else
  localparam logic [3:0] T2_PORTS = 4'b1010;
`endif

  initial begin
    logic [3:0] t2;
    int p;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arburst = '0;
    s_axi_rready = '1; m_axi_arready = 1'b0;
    m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = 2'b00; m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
    s3_arid = '0; s3_araddr = '0; s3_arlen = '0; s3_arsize = '0; s3_arburst = '0;
    s3_arvalid = '0; s3_rready = '0;
    m3_arready = 1'b0; m3_rid = '0; m3_rdata = '0; m3_rresp = '0; m3_rlast = 1'b0; m3_rvalid = 1'b0;
    set_port(0, 8'h10, 24'h000200, 8'd0);
    set_port(1, 8'h20, 24'h000300, 8'd0);
    s_axi_arvalid = 2'b11;

    // Reset state, with requests pending
    tick(); tick();
    check("rst_s_arready", 128'(s_axi_arready), 128'd0);
    check("rst_m_arvalid", 128'(m_axi_arvalid), 128'd0);
    check("rst_ar_regs", 128'({m_axi_arid, m_axi_araddr, m_axi_arlen}), 128'd0);
    check("const_ar", 128'({m_axi_arlock, m_axi_arcache, m_axi_arprot}), 128'({1'b0, 4'b0011, 3'b010}));
    rst = 1'b0;
    s_axi_arvalid = 2'b00;
    tick();

    // Single request from port 1 and its 4-beat burst
    set_port(1, 8'h05, 24'h000100, 8'd3);
    m_axi_arready = 1'b1;
    s_axi_arvalid = 2'b10;
    #1 check("t1_s_arready", 128'(s_axi_arready), 128'(2'b10));
    push_ar(1, 8'h05, 24'h000100, 8'd3);
    tick();
    check("t1_arvalid_lat", 128'({m_axi_arvalid, m_axi_arid}), 128'({1'b1, 8'h0B}));
    s_axi_arvalid = 2'b00;
    wait_ar_empty("t1_ar_drain");
    for (int i = 0; i < 4; i++) begin
      drive_r(1, 8'h05, 64'h1000 + 64'(i), i == 3);
      r_q.push_back({8'd1, 8'h05, 64'h1000 + 64'(i)});
      #1 check("t1_r_route", 128'({s_axi_rvalid, m_axi_rready}), 128'({2'b10, 1'b1}));
      tick();
    end
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;

    // Both ports requesting continuously
    set_port(0, 8'h10, 24'h000200, 8'd0);
    set_port(1, 8'h20, 24'h000300, 8'd0);
    t2 = T2_PORTS;
    for (int i = 0; i < 4; i++) begin
      p = int'(t2[i]);
      if (p == 0) push_ar(0, 8'h10, 24'h000200, 8'd0);
      else        push_ar(1, 8'h20, 24'h000300, 8'd0);
    end
    s_axi_arvalid = 2'b11;
    wait_ar_empty("t2_ar_drain");
    s_axi_arvalid = 2'b00;

    rst = 1'b1; tick(); rst = 1'b0; tick();

    // Outstanding limit on port 0; port 1 still served; rlast re-opens port 0
    set_port(0, 8'h10, 24'h000400, 8'd1);
    set_port(1, 8'h20, 24'h000500, 8'd2);
    for (int i = 0; i < 4; i++) push_ar(0, 8'h10, 24'h000400, 8'd1);
    s_axi_arvalid = 2'b01;
    wait_ar_empty("t3_ar_drain4");
    for (int i = 0; i < 3; i++) begin
      #1 check("t3_limit_block", 128'({s_axi_arready, m_axi_arvalid}), 128'd0);
      tick();
    end
    s_axi_arvalid = 2'b11;
    #1 check("t3_port1_grant", 128'(s_axi_arready), 128'(2'b10));
    push_ar(1, 8'h20, 24'h000500, 8'd2);
    tick();
    s_axi_arvalid = 2'b01;
    wait_ar_empty("t3_ar_drain_p1");
    drive_r(0, 8'h10, 64'hAA, 1'b1);
    r_q.push_back({8'd0, 8'h10, 64'hAA});
    #1 check("t3_still_blocked", 128'(s_axi_arready), 128'd0);
    tick();
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    #1 check("t3_fifth_grant", 128'(s_axi_arready), 128'(2'b01));
    push_ar(0, 8'h10, 24'h000400, 8'd1);
    tick();
    s_axi_arvalid = 2'b00;
    wait_ar_empty("t3_ar_drain5");

    // m_axi_arready held low: AR stays stable, no further grants
    set_port(1, 8'h03, 24'h000ABC, 8'd7);
    m_axi_arready = 1'b0;
    s_axi_arvalid = 2'b10;
    #1 check("t4_grant", 128'(s_axi_arready), 128'(2'b10));
    push_ar(1, 8'h03, 24'h000ABC, 8'd7);
    tick();
    set_port(1, 8'h7F, 24'h000FFF, 8'd0);
    s_axi_arvalid = 2'b11;
    for (int i = 0; i < 10; i++) begin
      #1 check("t4_hold", 128'({m_axi_arvalid, m_axi_arid, m_axi_araddr, m_axi_arlen, s_axi_arready}),
               128'({1'b1, 8'h07, 24'h000ABC, 8'd7, 2'b00}));
      tick();
    end
    s_axi_arvalid = 2'b00;
    m_axi_arready = 1'b1;
    wait_ar_empty("t4_ar_drain");

    // R backpressure on port 1, then sink of out-of-range index on the 3-port instance
    s_axi_rready = 2'b01;
    drive_r(1, 8'h05, 64'h55, 1'b0);
    #1 check("t5_bp", 128'({m_axi_rready, s_axi_rvalid}), 128'({1'b0, 2'b10}));
    tick();
    #1 check("t5_bp_hold", 128'(m_axi_rready), 128'd0);
    s_axi_rready = 2'b11;
    r_q.push_back({8'd1, 8'h05, 64'h55});
    #1 check("t5_release", 128'(m_axi_rready), 128'd1);
    tick();
    m_axi_rvalid = 1'b0;
    m3_rid = 8'h03; m3_rvalid = 1'b1; s3_rready = 3'b000;
    #1 check("t5_sink", 128'({m3_rready, s3_rvalid}), 128'({1'b1, 3'b000}));
    m3_rid = 8'h02;
    #1 check("t5_p2_bp", 128'({m3_rready, s3_rvalid}), 128'({1'b0, 3'b100}));
    m3_rvalid = 1'b0;
    tick();

    // Reset during ISSUE, stale rlast afterwards
    set_port(1, 8'h05, 24'h000100, 8'd3);
    m_axi_arready = 1'b0;
    s_axi_arvalid = 2'b10;
    tick();
    s_axi_arvalid = 2'b00;
    #1 check("t6_issue", 128'(m_axi_arvalid), 128'd1);
    rst = 1'b1;
    #1 check("t6_async_rst", 128'({m_axi_arvalid, m_axi_araddr}), 128'd0);
    tick();
    rst = 1'b0;
    m_axi_arready = 1'b1;
    drive_r(1, 8'h05, 64'h77, 1'b1);
    r_q.push_back({8'd1, 8'h05, 64'h77});
    tick();
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    s_axi_arvalid = 2'b10;
    #1 check("t6_no_underflow", 128'(s_axi_arready), 128'(2'b10));
    push_ar(1, 8'h05, 24'h000100, 8'd3);
    tick();
    s_axi_arvalid = 2'b00;
    wait_ar_empty("t6_ar_drain1");
    s_axi_arvalid = 2'b01;
    #1 check("t6_cnt_cleared", 128'(s_axi_arready), 128'(2'b01));
    push_ar(0, 8'h10, 24'h000400, 8'd1);
    tick();
    s_axi_arvalid = 2'b00;
    wait_ar_empty("t6_ar_drain0");

    tick();
    check("r_queue_empty", 128'(r_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
